// File: rtl/counter_event_monitor_pkg.sv
// Shared definitions for the counter event monitor.
//   ev_type_e : 2-bit event codes carried on ev_type (EV_NONE is never queued)
//   ev_rec_t  : queued event record {type, counter value}, EV_W bits wide
package counter_event_monitor_pkg;

  typedef enum logic [1:0] {
    EV_NONE  = 2'b00,
    EV_LOAD  = 2'b01,
    EV_WRAP  = 2'b10,
    EV_MATCH = 2'b11
  } ev_type_e;

  localparam int unsigned EV_W = 10;

  typedef struct packed {
    ev_type_e   typ;
    logic [7:0] value;
  } ev_rec_t;

endpackage

// File: rtl/counter_event_monitor_if.sv
// Event stream from the monitor to its consumer (valid/ready).
//   ev_valid : head of event queue valid          (master -> slave)
//   ev_ready : consumer accepts head this cycle   (slave -> master)
//   ev_type  : head event code                    (master -> slave)
//   ev_value : counter value captured with event  (master -> slave)
interface counter_event_monitor_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_type;
  logic [7:0] ev_value;

  modport master (output ev_valid, output ev_type, output ev_value, input ev_ready);
  modport slave  (input ev_valid, input ev_type, input ev_value, output ev_ready);
endinterface

// File: rtl/counter_event_monitor_event_fifo.sv
// Small synchronous FIFO for event records.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write din at the clock edge (caller ensures !full or pop)
//   pop        : drop the head at the clock edge (caller ensures !empty)
//   dout       : current head entry (meaningless while empty)
//   full,empty : occupancy flags
module event_fifo
  import counter_event_monitor_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = EV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Push into a full FIFO with a simultaneous pop overwrites the slot being
  // read out this cycle, so no bypass path is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/counter_event_monitor.sv
// Passive observer of an 8-bit loadable counter. Classifies LOAD, WRAP and
// MATCH events and queues them as {type,value} for a valid/ready consumer.
//   clk, reset        : clock, asynchronous active-high reset
//   cnt_data, cnt_wr  : observed counter value and its load strobe
//   cmp_en, cmp_val   : MATCH detection enable and compare value
//   ev (master)       : ev_valid/ev_ready/ev_type/ev_value event stream
//   ovf, ovf_clr      : sticky "event lost" flag and its clear
//   drop_cnt          : saturating count of lost events
module counter_event_monitor
  import counter_event_monitor_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               cnt_data,
  input  logic                     cnt_wr,
  input  logic                     cmp_en,
  input  logic [7:0]               cmp_val,
  counter_event_monitor_if.master  ev,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [DROP_W-1:0]        drop_cnt
);

  logic [7:0]  prev_data;
  logic        wr_d;
  logic        primed;

  logic        det_load, det_wrap, det_match;
  logic [1:0]  n_det;
  logic        push_req;
  ev_rec_t     push_rec;
  ev_rec_t     head;
  logic        fifo_full, fifo_empty;
  logic        pop, fifo_push, fifo_drop;
  logic [1:0]  drops;
  logic [DROP_W-1:0] drop_base;
  logic [DROP_W:0]   drop_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_data <= '0;
      wr_d      <= 1'b0;
      primed    <= 1'b0;
    end else begin
      prev_data <= cnt_data;
      wr_d      <= cnt_wr;
      primed    <= 1'b1;
    end
  end

  // The counter takes its load one edge after cnt_wr, so wr_d marks the
  // cycle in which cnt_data shows the loaded value.
  assign det_load  = primed && wr_d;
  assign det_wrap  = primed && !wr_d && (prev_data == 8'hFF) && (cnt_data == 8'h00);
  assign det_match = primed && cmp_en && (cnt_data == cmp_val) &&
                     ((prev_data != cmp_val) || wr_d);

  always_comb begin
    push_req = 1'b0;
    push_rec = '{typ: EV_NONE, value: cnt_data};
    n_det    = {1'b0, det_load} + {1'b0, det_wrap} + {1'b0, det_match};
    if (det_load) begin
      push_req     = 1'b1;
      push_rec.typ = EV_LOAD;
    end else if (det_wrap) begin
      push_req     = 1'b1;
      push_rec.typ = EV_WRAP;
    end else if (det_match) begin
      push_req     = 1'b1;
      push_rec.typ = EV_MATCH;
    end
  end

  assign pop       = !fifo_empty && ev.ev_ready;
  assign fifo_push = push_req && (!fifo_full || pop);
  assign fifo_drop = push_req && fifo_full && !pop;

  // Lost events this cycle: detections beyond the one pushed, plus the
  // pushed one itself if the FIFO could not take it (0..3).
  assign drops     = (n_det - {1'b0, push_req}) + {1'b0, fifo_drop};
  assign drop_base = ovf_clr ? '0 : drop_cnt;
  assign drop_sum  = {1'b0, drop_base} + {{(DROP_W-1){1'b0}}, drops};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ovf      <= (ovf && !ovf_clr) || (drops != 2'd0);
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (push_rec),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields read as zero while nothing is queued (also covers reset).
  assign ev.ev_valid = !fifo_empty;
  assign ev.ev_type  = fifo_empty ? 2'b00 : head.typ;
  assign ev.ev_value = fifo_empty ? 8'h00 : head.value;

endmodule

// File: tb/tb_counter_event_monitor.sv
// Directed bench for counter_event_monitor. The bench plays the role of the
// observed counter (free-running, loads wdata one edge after cnt_wr) and
// records every accepted event with the cycle index it was seen at.
module tb_counter_event_monitor;

  logic       clk;
  logic       reset;
  logic [7:0] cnt_data;
  logic       cnt_wr;
  logic [7:0] wdata;
  logic       cmp_en;
  logic [7:0] cmp_val;
  logic       ovf;
  logic       ovf_clr;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [9:0] q_ev[$];
  int         q_at[$];

  counter_event_monitor_if ev_if ();

  counter_event_monitor #(
    .DEPTH  (4),
    .DROP_W (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_data (cnt_data),
    .cnt_wr   (cnt_wr),
    .cmp_en   (cmp_en),
    .cmp_val  (cmp_val),
    .ev       (ev_if),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: the counter model advances exactly as the real counter would.
  task automatic step();
    @(posedge clk);
    #1;
    if (cnt_wr) cnt_data = wdata;
    else        cnt_data = cnt_data + 8'd1;
  endtask

  // Sample the stream before each edge; a valid&&ready sample is a pop.
  task automatic collect(input int n);
    q_ev.delete();
    q_at.delete();
    for (int i = 0; i < n; i++) begin
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        q_ev.push_back({ev_if.ev_type, ev_if.ev_value});
        q_at.push_back(i);
      end
      step();
    end
  endtask

  task automatic chk_ev(input string tag, input int idx, input logic [9:0] exp_ev, input int exp_at);
    if (idx < q_ev.size()) begin
      chk({tag, "_ev"}, 32'(q_ev[idx]), 32'(exp_ev));
      chk({tag, "_at"}, q_at[idx], exp_at);
    end else begin
      chk({tag, "_missing"}, q_ev.size(), idx + 1);
    end
  endtask

  initial begin
    reset = 1'b1;  cnt_data = 8'h00; cnt_wr = 1'b0; wdata = 8'h00;
    cmp_en = 1'b0; cmp_val = 8'h00;  ovf_clr = 1'b0; ev_if.ev_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ev_if.ev_valid, 0);
    chk("rst_type",  ev_if.ev_type,  0);
    chk("rst_value", ev_if.ev_value, 0);
    chk("rst_ovf",   ovf,            0);
    chk("rst_drop",  drop_cnt,       0);
    reset = 1'b0;

    // 1: free-run from 00; only event is WRAP 00, seen after edge 257.
    collect(258);
    chk("t1_count", q_ev.size(), 1);
    chk_ev("t1_wrap", 0, {2'b10, 8'h00}, 257);

    // 2: load 0x40; valid one cycle after the counter shows 0x40.
    cnt_wr = 1'b1; wdata = 8'h40;
    step();
    cnt_wr = 1'b0;
    chk("t2_cnt_shows", cnt_data, 8'h40);
    chk("t2_no_valid_yet", ev_if.ev_valid, 0);
    collect(3);
    chk("t2_count", q_ev.size(), 1);
    chk_ev("t2_load", 0, {2'b01, 8'h40}, 1);

    // 3: MATCH 05 once over 256 cycles (plus the WRAP on the way).
    cmp_en = 1'b1; cmp_val = 8'h05;
    collect(256);
    chk("t3_count", q_ev.size(), 2);
    chk_ev("t3_wrap",  0, {2'b10, 8'h00}, 190);
    chk_ev("t3_match", 1, {2'b11, 8'h05}, 195);
    // Load of the compare value: LOAD wins, MATCH counted as dropped.
    cnt_wr = 1'b1; wdata = 8'h05;
    step();
    cnt_wr = 1'b0;
    collect(3);
    chk("t3_ld_count", q_ev.size(), 1);
    chk_ev("t3_ld", 0, {2'b01, 8'h05}, 1);
    chk("t3_drop", drop_cnt, 1);
    chk("t3_ovf",  ovf,      1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_clr_ovf",  ovf,      0);
    chk("t3_clr_drop", drop_cnt, 0);
    cmp_en = 1'b0;

    // 4: six LOADs into a stalled 4-deep FIFO.
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cnt_wr = 1'b1; wdata = 8'h10 + 8'(i);
      step();
    end
    cnt_wr = 1'b0;
    step();
    chk("t4_valid", ev_if.ev_valid, 1);
    chk("t4_head",  {ev_if.ev_type, ev_if.ev_value}, {2'b01, 8'h10});
    chk("t4_ovf",   ovf,      1);
    chk("t4_drop",  drop_cnt, 2);
    step();
    chk("t4_hold",  {ev_if.ev_type, ev_if.ev_value}, {2'b01, 8'h10});
    ev_if.ev_ready = 1'b1;
    collect(5);
    chk("t4_drain_count", q_ev.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_ev($sformatf("t4_q%0d", i), i, {2'b01, 8'h10 + 8'(i)}, i);
    chk("t4_drop_kept", drop_cnt, 2);

    // 5: full FIFO with pop and new event in the same cycle.
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_wr = 1'b1; wdata = 8'h20 + 8'(i);
      step();
    end
    cnt_wr = 1'b0;
    step();
    cnt_wr = 1'b1; wdata = 8'h30;
    step();
    cnt_wr = 1'b0; ev_if.ev_ready = 1'b1;
    step();
    ev_if.ev_ready = 1'b0;
    chk("t5_popfull_drop", drop_cnt, 0);
    chk("t5_popfull_ovf",  ovf,      0);
    chk("t5_head", {ev_if.ev_type, ev_if.ev_value}, {2'b01, 8'h21});
    // Drop in the same cycle as ovf_clr: the drop wins.
    cnt_wr = 1'b1; wdata = 8'h41;
    step();
    wdata = 8'h42;
    step();
    chk("t5_pre_drop", drop_cnt, 1);
    cnt_wr = 1'b0; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t5_clr_drop", drop_cnt, 1);
    chk("t5_clr_ovf",  ovf,      1);

    // 6: reset with three events queued.
    ev_if.ev_ready = 1'b1;
    step();
    ev_if.ev_ready = 1'b0;
    chk("t6_head", {ev_if.ev_type, ev_if.ev_value}, {2'b01, 8'h22});
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", ev_if.ev_valid, 0);
    chk("t6_rst_drop",  drop_cnt,       0);
    chk("t6_rst_ovf",   ovf,            0);
    @(posedge clk);
    #1;
    reset = 1'b0; cnt_data = 8'h00; cnt_wr = 1'b0; ev_if.ev_ready = 1'b1;
    collect(5);
    chk("t6_no_stale", q_ev.size(), 0);
    chk("t6_valid_end", ev_if.ev_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
